// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   - state_t   : controller states (IDLE, MULT, DIV, FINISH)
//   - OP_MULT / OP_DIV : encodings of the op input
//   - MDU_WIDTH : default operand width
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/booth_mult_core.sv
// Radix-2 Booth multiplier datapath: one Booth step per enabled cycle.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load           : capture multiplicand/multiplier, clear partial product
//   step           : perform one add/sub + arithmetic shift step
//   mcand_in       : multiplicand (signed)
//   mplier_in      : multiplier (signed)
//   prod_next      : product as it will be after the current step
//                    (lets the owner capture the final result on the last step)
module booth_mult_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      step,
  input  logic signed [WIDTH-1:0]   mcand_in,
  input  logic signed [WIDTH-1:0]   mplier_in,
  output logic signed [2*WIDTH-1:0] prod_next
);

  // Accumulator layout: [2W:W+1] partial product, [W:1] multiplier, [0] q(-1)
  logic        [2*WIDTH:0]   acc_q, acc_d;
  logic signed [WIDTH-1:0]   mcand_q, mcand_d;
  logic signed [WIDTH:0]     part_ext;
  logic signed [WIDTH:0]     mcand_ext;
  logic signed [WIDTH:0]     sum;
  logic        [2*WIDTH:0]   acc_step;

  always_comb begin
    // The add/sub is done one bit wider so a most-negative multiplicand
    // cannot overflow; the shift then drops the extra bit again.
    part_ext  = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    mcand_ext = {mcand_q[WIDTH-1], mcand_q};
    case (acc_q[1:0])
      2'b01:   sum = part_ext + mcand_ext;
      2'b10:   sum = part_ext - mcand_ext;
      default: sum = part_ext;
    endcase
    acc_step  = {sum, acc_q[WIDTH:1]};
    prod_next = acc_step[2*WIDTH:1];

    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (load) begin
      mcand_d = mcand_in;
      acc_d   = {{WIDTH{1'b0}}, mplier_in, 1'b0};
    end else if (step) begin
      acc_d = acc_step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply / divide unit (start/done responder).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle request, only accepted in IDLE
//   op         : 0 = signed multiply, 1 = signed divide
//   a_in, b_in : multiplicand/dividend, multiplier/divisor
//   busy       : high while iterating
//   done       : one-cycle completion pulse
//   div_zero   : divide by zero flag, held until the next accepted start
//   hi_out     : product upper half or remainder
//   lo_out     : product lower half or quotient
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  output logic                    busy,
  output logic                    done,
  output logic                    div_zero,
  output logic        [WIDTH-1:0] hi_out,
  output logic        [WIDTH-1:0] lo_out
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    // -2^(W-1) maps onto itself, which is the correct unsigned magnitude
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic                      mult_load;
  logic                      mult_step;
  logic signed [2*WIDTH-1:0] prod_next;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  booth_mult_core #(.WIDTH(WIDTH)) u_booth (
    .clk       (clk),
    .reset     (reset),
    .load      (mult_load),
    .step      (mult_step),
    .mcand_in  (a_in),
    .mplier_in (b_in),
    .prod_next (prod_next)
  );

  always_comb begin
    // Restoring divide step: shift in the next dividend bit, try subtracting
    trial    = {rem_q, dvd_q[WIDTH-1]};
    diff     = trial - {1'b0, dvs_q};
    q_bit    = ~diff[WIDTH];
    rem_step = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {dvd_q[WIDTH-2:0], q_bit};

    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mult_load  = 1'b0;
    mult_step  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          div_zero_d = 1'b0;
          if (op == OP_DIV && b_in == '0) begin
            // Skip iteration entirely; results are left as they were
            state_d    = FINISH;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            cnt_d  = '0;
            busy_d = 1'b1;
            if (op == OP_MULT) begin
              mult_load = 1'b1;
              state_d   = MULT;
            end else begin
              dvd_d     = abs_val(a_in);
              dvs_d     = abs_val(b_in);
              rem_d     = '0;
              neg_quo_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
              neg_rem_d = a_in[WIDTH-1];
              state_d   = DIV;
            end
          end
        end
      end
      MULT: begin
        mult_step = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = prod_next[2*WIDTH-1:WIDTH];
          lo_d    = prod_next[WIDTH-1:0];
        end
      end
      DIV: begin
        dvd_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = cond_neg(rem_step, neg_rem_q);
          lo_d    = cond_neg(quo_step, neg_quo_q);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_checks = 0;
  int n_pass   = 0;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  // Launch one operation (start high in cycle 0) and follow it until done.
  // Cycle c is the cycle after the c-th rising edge following start.
  // pulse_at > 0 issues an extra divide-by-zero start in that cycle.
  task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input int pulse_at, output int done_cyc, output int busy_cnt,
                        output int busy_first, output logic dz_c1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = op_i; a_in = a_i; b_in = b_i;
    done_cyc = -1; busy_cnt = 0; busy_first = -1; dz_c1 = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        start = 1'b0;
        dz_c1 = div_zero;
      end
      if (c == pulse_at) begin
        start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd0;
      end
      if (c == pulse_at + 1) start = 1'b0;
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_checks++; if (div_zero !== 1'b0) $display("FAIL rst_dz got %b want 0", div_zero); else n_pass++;
    n_checks++; if (hi_out !== 32'h0) $display("FAIL rst_hi got %h want 0", hi_out); else n_pass++;
    n_checks++; if (lo_out !== 32'h0) $display("FAIL rst_lo got %h want 0", lo_out); else n_pass++;
    // reset beats a simultaneous start
    start = 1'b1; op = 1'b0; a_in = 32'd5; b_in = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_vs_start_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_mult;
    int dc, bc, bf; logic dz;
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, 0, dc, bc, bf, dz);
    n_checks++; if (dc != 33) $display("FAIL mul_done_cycle got %0d want 33", dc); else n_pass++;
    n_checks++; if (bc != 32) $display("FAIL mul_busy_cycles got %0d want 32", bc); else n_pass++;
    n_checks++; if (bf != 1) $display("FAIL mul_busy_first got %0d want 1", bf); else n_pass++;
    n_checks++; if (hi_out !== 32'hFFFFFFFF) $display("FAIL mul_neg_hi got %h want ffffffff", hi_out); else n_pass++;
    n_checks++; if (lo_out !== 32'hFFFFFFEB) $display("FAIL mul_neg_lo got %h want ffffffeb", lo_out); else n_pass++;
    n_checks++; if (div_zero !== 1'b0) $display("FAIL mul_neg_dz got %b want 0", div_zero); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) $display("FAIL mul_done_width got %b want 0", done); else n_pass++;

    run_op(1'b0, 32'h80000000, 32'h80000000, 0, dc, bc, bf, dz);
    n_checks++; if (hi_out !== 32'h40000000) $display("FAIL mul_min_hi got %h want 40000000", hi_out); else n_pass++;
    n_checks++; if (lo_out !== 32'h00000000) $display("FAIL mul_min_lo got %h want 00000000", lo_out); else n_pass++;

    run_op(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, dc, bc, bf, dz);
    n_checks++; if (hi_out !== 32'h3FFFFFFF) $display("FAIL mul_max_hi got %h want 3fffffff", hi_out); else n_pass++;
    n_checks++; if (lo_out !== 32'h00000001) $display("FAIL mul_max_lo got %h want 00000001", lo_out); else n_pass++;
  endtask

  task automatic test_div;
    int dc, bc, bf; logic dz;
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, dc, bc, bf, dz);
    n_checks++; if (dc != 33) $display("FAIL div_done_cycle got %0d want 33", dc); else n_pass++;
    n_checks++; if (lo_out !== 32'hFFFFFFFD) $display("FAIL div_neg_lo got %h want fffffffd", lo_out); else n_pass++;
    n_checks++; if (hi_out !== 32'hFFFFFFFF) $display("FAIL div_neg_hi got %h want ffffffff", hi_out); else n_pass++;
    n_checks++; if (div_zero !== 1'b0) $display("FAIL div_neg_dz got %b want 0", div_zero); else n_pass++;

    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0, dc, bc, bf, dz);
    n_checks++; if (lo_out !== 32'hFFFFFFFD) $display("FAIL div_negb_lo got %h want fffffffd", lo_out); else n_pass++;
    n_checks++; if (hi_out !== 32'h00000001) $display("FAIL div_negb_hi got %h want 00000001", hi_out); else n_pass++;
  endtask

  task automatic test_div_zero;
    int dc, bc, bf; logic dz;
    // previous result: hi = 1, lo = fffffffd
    run_op(1'b1, 32'd100, 32'd0, 0, dc, bc, bf, dz);
    n_checks++; if (dc != 1) $display("FAIL dz_done_cycle got %0d want 1", dc); else n_pass++;
    n_checks++; if (bc != 0) $display("FAIL dz_busy_cycles got %0d want 0", bc); else n_pass++;
    n_checks++; if (div_zero !== 1'b1) $display("FAIL dz_flag got %b want 1", div_zero); else n_pass++;
    n_checks++; if (hi_out !== 32'h00000001) $display("FAIL dz_hi_held got %h want 00000001", hi_out); else n_pass++;
    n_checks++; if (lo_out !== 32'hFFFFFFFD) $display("FAIL dz_lo_held got %h want fffffffd", lo_out); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (div_zero !== 1'b1) $display("FAIL dz_flag_hold got %b want 1", div_zero); else n_pass++;

    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, dc, bc, bf, dz);
    n_checks++; if (dz !== 1'b0) $display("FAIL dz_clear_on_start got %b want 0", dz); else n_pass++;
    n_checks++; if (lo_out !== 32'h80000000) $display("FAIL div_min_lo got %h want 80000000", lo_out); else n_pass++;
    n_checks++; if (hi_out !== 32'h00000000) $display("FAIL div_min_hi got %h want 00000000", hi_out); else n_pass++;
    n_checks++; if (div_zero !== 1'b0) $display("FAIL div_min_dz got %b want 0", div_zero); else n_pass++;
  endtask

  task automatic test_abort;
    int dc, bc, bf; logic dz;
    logic saw_done;
    saw_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_in = 32'd9; b_in = 32'd9;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
      if (c == 10) begin start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd0; end
      if (c == 11) start = 1'b0;
      if (c == 20) reset = 1'b1;
      if (c == 21) begin
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (div_zero !== 1'b0) $display("FAIL abort_dz got %b want 0", div_zero); else n_pass++;
        n_checks++; if ({hi_out, lo_out} !== 64'h0) $display("FAIL abort_hilo got %h want 0", {hi_out, lo_out}); else n_pass++;
      end
      if (done) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) $display("FAIL abort_no_done got %b want 0", saw_done); else n_pass++;

    run_op(1'b0, 32'd3, 32'd4, 0, dc, bc, bf, dz);
    n_checks++; if (dc != 33) $display("FAIL post_abort_cycle got %0d want 33", dc); else n_pass++;
    n_checks++; if (lo_out !== 32'd12) $display("FAIL post_abort_lo got %h want 0000000c", lo_out); else n_pass++;
    n_checks++; if (hi_out !== 32'd0) $display("FAIL post_abort_hi got %h want 00000000", hi_out); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int dc, bc, bf; logic dz;
    // a divide-by-zero start mid-operation must be ignored
    run_op(1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 10, dc, bc, bf, dz);
    n_checks++; if (dc != 33) $display("FAIL busy_start_cycle got %0d want 33", dc); else n_pass++;
    n_checks++; if (lo_out !== 32'd30) $display("FAIL busy_start_lo got %h want 0000001e", lo_out); else n_pass++;
    n_checks++; if (hi_out !== 32'd0) $display("FAIL busy_start_hi got %h want 00000000", hi_out); else n_pass++;
    n_checks++; if (div_zero !== 1'b0) $display("FAIL busy_start_dz got %b want 0", div_zero); else n_pass++;
    // start raised during the done cycle is ignored
    start = 1'b1; op = 1'b0; a_in = 32'd2; b_in = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL done_start_ignored got busy=%b done=%b want 0 0", busy, done); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL done_start_idle got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
